// File: rtl/parse_sampler_if.sv
// Block/polynomial bus between the SHAKE-128 XOF, the Parse sampler and the matrix-A logic.
interface parse_sampler_if #(
  parameter int BLK_BITS = 3072,
  parameter int CNT_W    = 9
);
  logic                  start;
  logic [0:BLK_BITS-1]   blk;
  logic                  blk_valid;
  logic                  blk_ready;
  logic                  more;
  logic [0:BLK_BITS-1]   poly;
  logic [CNT_W-1:0]      cnt;
  logic                  done;

  modport master (
    output start, blk, blk_valid,
    input  blk_ready, more, poly, cnt, done
  );

  modport slave (
    input  start, blk, blk_valid,
    output blk_ready, more, poly, cnt, done
  );
endinterface

// File: rtl/parse_sampler.sv
// Kyber Parse / SampleNTT rejection sampler: splits XOF byte-triples into two 12-bit
// candidates, keeps those below Q and packs N of them into a polynomial.
module parse_sampler #(
  parameter int Q        = 3329,
  parameter int N        = 256,
  parameter int BLK_BITS = 3072,
  parameter int COEF_W   = 12
) (
  input logic            clk,
  input logic            rst,
  parse_sampler_if.slave bus
);
  localparam int TRIPLES = BLK_BITS / 24;
  localparam int IDX_W   = $clog2(BLK_BITS);
  localparam int T_W     = $clog2(TRIPLES);
  localparam int CNT_W   = $clog2(N + 1);
  localparam logic [COEF_W-1:0] Q_C    = COEF_W'(Q);
  localparam logic [CNT_W-1:0]  N_C    = CNT_W'(N);
  localparam logic [T_W-1:0]    T_LAST = T_W'(TRIPLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, PARSE, DONE} state_t;

  state_t              state;
  logic [T_W-1:0]      t;
  logic [CNT_W-1:0]    cnt;
  logic [0:BLK_BITS-1] poly;
  logic [0:BLK_BITS-1] blk_p0;
  logic                blk_ready;
  logic                more;
  logic                done;

  // Bit 8k of the block is the LSB of byte k, so the three bytes read as a
  // little-endian 24-bit word once the bit order is flipped.
  function automatic logic [23:0] triple_word(input logic [0:23] bits);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[i] = bits[i];
    return w;
  endfunction

  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  widx1;
  logic [IDX_W-1:0]  widx2;
  logic [23:0]       word;
  logic [COEF_W-1:0] d1;
  logic [COEF_W-1:0] d2;
  logic              acc1;
  logic              acc2;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;

  // Stage p0 -> candidate split and accept decision for triple t
  always_comb begin
    base  = IDX_W'(t) * IDX_W'(24);
    word  = triple_word(blk_p0[base +: 24]);
    d1    = word[11:0];
    d2    = word[23:12];
    acc1  = (d1 < Q_C) && (cnt < N_C);
    cnt1  = cnt + CNT_W'(acc1);
    acc2  = (d2 < Q_C) && (cnt1 < N_C);
    cnt2  = cnt1 + CNT_W'(acc2);
    widx1 = IDX_W'(cnt) * IDX_W'(COEF_W);
    widx2 = IDX_W'(cnt1) * IDX_W'(COEF_W);
  end

  always_ff @(posedge clk) begin
    if (state == WAIT && bus.blk_valid) blk_p0 <= bus.blk;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      t         <= '0;
      cnt       <= '0;
      poly      <= '0;
      blk_ready <= 1'b0;
      more      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= WAIT;
            t         <= '0;
            cnt       <= '0;
            poly      <= '0;
            more      <= 1'b0;
            blk_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.blk_valid) begin
            state     <= PARSE;
            t         <= '0;
            more      <= 1'b0;
            blk_ready <= 1'b0;
          end
        end
        PARSE: begin
          if (acc1) poly[widx1 +: COEF_W] <= d1;
          if (acc2) poly[widx2 +: COEF_W] <= d2;
          cnt <= cnt2;
          if (cnt2 == N_C) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (t == T_LAST) begin
            state     <= WAIT;
            more      <= 1'b1;
            blk_ready <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state     <= WAIT;
            t         <= '0;
            cnt       <= '0;
            poly      <= '0;
            more      <= 1'b0;
            done      <= 1'b0;
            blk_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready = blk_ready;
  assign bus.more      = more;
  assign bus.poly      = poly;
  assign bus.cnt       = cnt;
  assign bus.done      = done;
endmodule
